ub_input_setup: RTL and testbench

- Downstream consumer of the unified buffer. On a start pulse it reads one N x N activation tile (row-major, N*N consecutive words) through a synchronous read port.
- Holds the tile in local registers, then streams it into the systolic array's row inputs with diagonal skew: row r is delayed r cycles.
- Signals busy for the whole operation and pulses done when finished.

---
 rtl/tpu_pkg.sv | 15 +
 rtl/ub_input_setup_skew_shifter.sv | 40 ++++
 rtl/ub_input_setup.sv | 162 ++++++++++++++++
 tb/tb_ub_input_setup.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared constants for the unified-buffer consumer blocks: FSM state
// encodings, default word/address widths and the buffer depth.
package tpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 6;
  localparam int UB_DEPTH   = 64;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_STREAM = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/ub_input_setup_skew_shifter.sv
// Per-row delay lines: row r passes through r+1 register stages, turning an
// aligned column vector into the diagonally skewed stream the array expects.
module skew_shifter #(
  parameter int DATA_W = 32,
  parameter int N      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic [N-1:0]        in_valid,
  output logic [N*DATA_W-1:0] out_data,
  output logic [N-1:0]        out_valid
);

  for (genvar r = 0; r < N; r++) begin : g_row
    logic [DATA_W-1:0] data_r [r+1];
    logic [r:0]        valid_r;

    // Shift row r one stage per clock; the last stage is the registered output.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_r <= '0;
        for (int s = 0; s <= r; s++) begin
          data_r[s] <= '0;
        end
      end else begin
        valid_r[0] <= in_valid[r];
        data_r[0]  <= in_data[r*DATA_W +: DATA_W];
        for (int s = 1; s <= r; s++) begin
          valid_r[s] <= valid_r[s-1];
          data_r[s]  <= data_r[s-1];
        end
      end
    end

    assign out_data[r*DATA_W +: DATA_W] = data_r[r];
    assign out_valid[r]                 = valid_r[r];
  end

endmodule

// File: rtl/ub_input_setup.sv
// Reads an N x N activation tile from the unified buffer into local registers,
// then streams it row-skewed into the systolic array inputs.
module ub_input_setup
  import tpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N      = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic                ub_rd_en,
  output logic [ADDR_W-1:0]   ub_rd_addr,
  input  logic [DATA_W-1:0]   ub_rd_data,
  output logic [N*DATA_W-1:0] a_out,
  output logic [N-1:0]        a_valid
);

  localparam int CNT_W  = $clog2(N*N+1);
  localparam int STEP_W = $clog2(2*N);
  localparam int TI_W   = (N > 1) ? $clog2(N*N) : 1;
  localparam int COL_W  = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(N*N-1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(2*N-2);

  logic [2:0]        state_r;
  logic [CNT_W-1:0]  idx_r;
  logic [CNT_W-1:0]  cap_idx_r;
  logic              cap_valid_r;
  logic [STEP_W-1:0] step_r;
  logic [DATA_W-1:0] tile_r [N*N];

  logic                feed_valid_s;
  logic [COL_W-1:0]    feed_col_s;
  logic [31:0]         flat_s;
  logic [N*DATA_W-1:0] feed_data_s;

  // Sequencer: issues the N*N reads, waits one drain cycle, counts stream steps.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      step_r     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ub_rd_en   <= 1'b0;
      ub_rd_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_FETCH;
            busy       <= 1'b1;
            ub_rd_en   <= 1'b1;
            ub_rd_addr <= base_addr;
            idx_r      <= '0;
            step_r     <= '0;
          end
        end
        ST_FETCH: begin
          if (idx_r == LAST_IDX) begin
            state_r    <= ST_DRAIN;
            ub_rd_en   <= 1'b0;
            ub_rd_addr <= '0;
          end else begin
            idx_r      <= idx_r + CNT_W'(1);
            ub_rd_addr <= ub_rd_addr + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          state_r <= ST_STREAM;
          step_r  <= '0;
        end
        ST_STREAM: begin
          if (step_r == LAST_STEP) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
          end else begin
            step_r <= step_r + STEP_W'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state_r  <= ST_IDLE;
          busy     <= 1'b0;
          ub_rd_en <= 1'b0;
        end
      endcase
    end
  end

  // Capture each read word the cycle after its strobe, into row-major tile order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_valid_r <= 1'b0;
      cap_idx_r   <= '0;
      for (int i = 0; i < N*N; i++) begin
        tile_r[i] <= '0;
      end
    end else begin
      cap_valid_r <= ub_rd_en;
      cap_idx_r   <= idx_r;
      if (cap_valid_r) begin
        tile_r[cap_idx_r[TI_W-1:0]] <= ub_rd_data;
      end
    end
  end

  // Column k is fed one cycle before stream step k so the shifter output lands on time.
  always_comb begin
    feed_valid_s = 1'b0;
    feed_col_s   = '0;
    if (state_r == ST_DRAIN) begin
      feed_valid_s = 1'b1;
      feed_col_s   = '0;
    end else if ((state_r == ST_STREAM) && (int'(step_r) < N - 1)) begin
      feed_valid_s = 1'b1;
      feed_col_s   = COL_W'(int'(step_r) + 1);
    end else begin
      feed_valid_s = 1'b0;
      feed_col_s   = '0;
    end
  end

  // Select column elements; forward the word still being captured, if needed.
  always_comb begin
    feed_data_s = '0;
    flat_s      = '0;
    for (int r = 0; r < N; r++) begin
      flat_s = 32'(r*N) + 32'(feed_col_s);
      if (feed_valid_s && cap_valid_r && (32'(cap_idx_r) == flat_s)) begin
        feed_data_s[r*DATA_W +: DATA_W] = ub_rd_data;
      end else if (feed_valid_s) begin
        feed_data_s[r*DATA_W +: DATA_W] = tile_r[flat_s[TI_W-1:0]];
      end else begin
        feed_data_s[r*DATA_W +: DATA_W] = '0;
      end
    end
  end

  skew_shifter #(
    .DATA_W (DATA_W),
    .N      (N)
  ) u_skew (
    .clk       (clk),
    .reset     (reset),
    .in_data   (feed_data_s),
    .in_valid  ({N{feed_valid_s}}),
    .out_data  (a_out),
    .out_valid (a_valid)
  );

endmodule

// File: tb/tb_ub_input_setup.sv
// Directed bench for ub_input_setup (N=2): cycle-by-cycle checks of reads,
// skewed row stream, busy/done, wrap, ignored start, mid-stream reset and idle hold.
module tb_ub_input_setup;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int N  = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [AW-1:0]   base_addr;
  logic            busy;
  logic            done;
  logic            ub_rd_en;
  logic [AW-1:0]   ub_rd_addr;
  logic [DW-1:0]   ub_rd_data;
  logic [N*DW-1:0] a_out;
  logic [N-1:0]    a_valid;

  logic [DW-1:0] mem [64];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Unified buffer model: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    ub_rd_data <= ub_rd_en ? mem[ub_rd_addr] : $urandom();
  end

  ub_input_setup #(.DATA_W(DW), .ADDR_W(AW), .N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .busy       (busy),
    .done       (done),
    .ub_rd_en   (ub_rd_en),
    .ub_rd_addr (ub_rd_addr),
    .ub_rd_data (ub_rd_data),
    .a_out      (a_out),
    .a_valid    (a_valid)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, " busy"},    64'(busy),     64'd0);
    check_eq({tag, " done"},    64'(done),     64'd0);
    check_eq({tag, " rd_en"},   64'(ub_rd_en), 64'd0);
    check_eq({tag, " a_valid"}, 64'(a_valid),  64'd0);
    check_eq({tag, " a_out"},   64'(a_out),    64'd0);
  endtask

  // Start a tile from a negedge; checks cycles 1..9 after the accepting edge.
  task automatic run_tile(input string name, input logic [AW-1:0] base,
                          input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                          input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                          input int extra_cycle, input int reset_cycle);
    logic [DW-1:0] w [4];
    logic          aborted;
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic [1:0]    exp_val;
    logic [DW-1:0] exp_r0;
    logic [DW-1:0] exp_r1;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    base_addr = base;
    start     = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == extra_cycle) begin
        start = 1'b1; base_addr = 6'd20;
      end else if (c == extra_cycle + 1) begin
        start = 1'b0; base_addr = base;
      end
      aborted    = (reset_cycle != 0) && (c > reset_cycle);
      exp_en     = !aborted && (c <= 4);
      exp_addr   = base + AW'(c - 1);
      exp_val[0] = !aborted && (c == 6 || c == 7);
      exp_val[1] = !aborted && (c == 7 || c == 8);
      exp_r0 = aborted ? 32'd0 : (c == 6) ? w[0] : (c == 7) ? w[1] : 32'd0;
      exp_r1 = aborted ? 32'd0 : (c == 7) ? w[2] : (c == 8) ? w[3] : 32'd0;
      check_eq($sformatf("%s c%0d rd_en", name, c), 64'(ub_rd_en), 64'(exp_en));
      if (exp_en) check_eq($sformatf("%s c%0d rd_addr", name, c), 64'(ub_rd_addr), 64'(exp_addr));
      check_eq($sformatf("%s c%0d busy", name, c), 64'(busy), 64'(!aborted));
      check_eq($sformatf("%s c%0d done", name, c), 64'(done), 64'(!aborted && c == 9));
      check_eq($sformatf("%s c%0d a_valid", name, c), 64'(a_valid), 64'(exp_val));
      check_eq($sformatf("%s c%0d a_out", name, c), 64'(a_out), {exp_r1, exp_r0});
      if (reset_cycle != 0 && c == reset_cycle) reset = 1'b1;
      if (reset_cycle != 0 && c == reset_cycle + 1) reset = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    mem[8] = 32'd1; mem[9] = 32'd2; mem[10] = 32'd3; mem[11] = 32'd4;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check_eq("reset rd_addr", 64'(ub_rd_addr), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_tile("basic", 6'd8, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0);
    @(negedge clk);
    check_idle("basic c10");

    mem[62] = 32'hA; mem[63] = 32'hB; mem[0] = 32'hC; mem[1] = 32'hD;
    run_tile("wrap", 6'd62, 32'hA, 32'hB, 32'hC, 32'hD, 0, 0);
    @(negedge clk);
    check_idle("wrap c10");

    run_tile("busy_start", 6'd8, 32'd1, 32'd2, 32'd3, 32'd4, 3, 0);
    for (int c = 10; c <= 12; c++) begin
      @(negedge clk);
      check_idle($sformatf("busy_start c%0d", c));
    end

    run_tile("mid_reset", 6'd8, 32'd1, 32'd2, 32'd3, 32'd4, 0, 6);
    mem[2] = 32'h33; mem[3] = 32'h44;
    @(negedge clk);
    check_idle("post_reset idle");
    run_tile("after_reset", 6'd0, 32'hC, 32'hD, 32'h33, 32'h44, 0, 0);

    @(negedge clk);
    run_tile("b2b_first", 6'd8, 32'd1, 32'd2, 32'd3, 32'd4, 0, 0);
    @(negedge clk);
    check_idle("b2b c10");
    run_tile("b2b_second", 6'd62, 32'hA, 32'hB, 32'hC, 32'hD, 0, 0);

    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_eq($sformatf("idle_hold %0d rd_en", c), 64'(ub_rd_en), 64'd0);
      check_eq($sformatf("idle_hold %0d a_valid", c), 64'(a_valid), 64'd0);
      check_eq($sformatf("idle_hold %0d busy", c), 64'(busy), 64'd0);
    end

    start = 1'b1; reset = 1'b1; base_addr = 6'd8;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    check_idle("rst_and_start c1");
    @(negedge clk);
    check_idle("rst_and_start c2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
